// File: rtl/logic_seq.sv
// rtl/logic_seq.sv - multi-cycle logic-op sequencer over shared and32/or32/not32 primitives (optional LOGIC_SEQ_ERR_EN adds rsp_err)

// and32 - WIDTH-bit bitwise AND primitive
module and32 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] z
);
  assign z = a & b;
endmodule

// or32 - WIDTH-bit bitwise OR primitive
module or32 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] z
);
  assign z = a | b;
endmodule

// not32 - WIDTH-bit bitwise NOT primitive
module not32 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] z
);
  assign z = ~a;
endmodule

// logic_seq - sequencer top
module logic_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_x,
  input  logic [WIDTH-1:0] req_y,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_z,
  output logic             busy
`ifdef LOGIC_SEQ_ERR_EN
  ,
  output logic             rsp_err
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NOT  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_XNOR = 3'd6;

  localparam logic [1:0] PRIM_AND  = 2'd0;
  localparam logic [1:0] PRIM_OR   = 2'd1;
  localparam logic [1:0] PRIM_NOT  = 2'd2;
  localparam logic [1:0] PRIM_ZERO = 2'd3;

  localparam logic [1:0] SRC_X = 2'd0;
  localparam logic [1:0] SRC_Y = 2'd1;
  localparam logic [1:0] SRC_T = 2'd2;
  localparam logic [1:0] SRC_U = 2'd3;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] x_q, y_q, t_q, u_q, rsp_z_q;
  logic [2:0]       op_q;
  logic [2:0]       step_q;

  logic [1:0]       prim, src_a, src_b;
  logic             dst_u, last;
  logic [WIDTH-1:0] opa, opb, and_z, or_z, not_z, prim_z;

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign busy      = (state != S_IDLE);
  assign rsp_z     = rsp_z_q;
`ifdef LOGIC_SEQ_ERR_EN
  assign rsp_err   = rsp_valid && (op_q == 3'd7);
`endif

  // Micro-op decode: which primitive, which sources, which temporary, and whether this is the final step
  always_comb begin
    prim  = PRIM_ZERO;
    src_a = SRC_X;
    src_b = SRC_Y;
    dst_u = 1'b0;
    last  = 1'b1;
    case (op_q)
      OP_AND: prim = PRIM_AND;
      OP_OR:  prim = PRIM_OR;
      OP_NOT: prim = PRIM_NOT;
      OP_NAND, OP_NOR: begin
        if (step_q == 3'd0) begin
          prim = (op_q == OP_NAND) ? PRIM_AND : PRIM_OR;
          last = 1'b0;
        end else begin
          prim  = PRIM_NOT;
          src_a = SRC_T;
        end
      end
      OP_XOR, OP_XNOR: begin
        // x^y = (x|y) & ~(x&y); XNOR inverts that once more
        case (step_q)
          3'd0: begin
            prim = PRIM_OR;
            last = 1'b0;
          end
          3'd1: begin
            prim  = PRIM_AND;
            dst_u = 1'b1;
            last  = 1'b0;
          end
          3'd2: begin
            prim  = PRIM_NOT;
            src_a = SRC_U;
            dst_u = 1'b1;
            last  = 1'b0;
          end
          3'd3: begin
            prim  = PRIM_AND;
            src_a = SRC_T;
            src_b = SRC_U;
            last  = (op_q == OP_XOR);
          end
          default: begin
            prim  = PRIM_NOT;
            src_a = SRC_T;
          end
        endcase
      end
      default: prim = PRIM_ZERO;
    endcase
  end

  // Operand muxes feeding the single shared set of primitives
  always_comb begin
    opa = x_q;
    opb = y_q;
    case (src_a)
      SRC_X:   opa = x_q;
      SRC_Y:   opa = y_q;
      SRC_T:   opa = t_q;
      default: opa = u_q;
    endcase
    case (src_b)
      SRC_X:   opb = x_q;
      SRC_Y:   opb = y_q;
      SRC_T:   opb = t_q;
      default: opb = u_q;
    endcase
  end

  and32 #(.WIDTH(WIDTH)) u_and (.a(opa), .b(opb), .z(and_z));
  or32  #(.WIDTH(WIDTH)) u_or  (.a(opa), .b(opb), .z(or_z));
  not32 #(.WIDTH(WIDTH)) u_not (.a(opa), .z(not_z));

  // Select the primitive output for this micro-op
  always_comb begin
    prim_z = '0;
    case (prim)
      PRIM_AND: prim_z = and_z;
      PRIM_OR:  prim_z = or_z;
      PRIM_NOT: prim_z = not_z;
      default:  prim_z = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req_valid) state_nxt = S_EXEC;
      S_EXEC:  if (last) state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand latch, temporaries, step counter and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q     <= '0;
      y_q     <= '0;
      op_q    <= '0;
      step_q  <= '0;
      t_q     <= '0;
      u_q     <= '0;
      rsp_z_q <= '0;
    end else if (state == S_IDLE) begin
      if (req_valid) begin
        x_q    <= req_x;
        y_q    <= req_y;
        op_q   <= req_op;
        step_q <= '0;
      end
    end else if (state == S_EXEC) begin
      if (dst_u) u_q <= prim_z;
      else       t_q <= prim_z;
      step_q <= step_q + 3'd1;
      if (last) rsp_z_q <= prim_z;
    end
  end

endmodule

// File: tb/tb_logic_seq.sv
// tb/tb_logic_seq.sv - directed self-checking bench for logic_seq
module tb_logic_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_x;
  logic [31:0] req_y;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_z;
  logic        busy;
`ifdef LOGIC_SEQ_ERR_EN
  logic        rsp_err;
`endif

  int checks = 0;
  int failures = 0;

  logic_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_x     (req_x),
    .req_y     (req_y),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_z     (rsp_z),
    .busy      (busy)
`ifdef LOGIC_SEQ_ERR_EN
    ,
    .rsp_err   (rsp_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction with rsp_ready held high; checks latency, result, busy and ready recovery
  task automatic run(input string tag, input logic [2:0] op, input logic [31:0] x,
                     input logic [31:0] y, input logic [31:0] exp_z, input int exp_n);
    int n;
    req_valid = 1'b1;
    req_op    = op;
    req_x     = x;
    req_y     = y;
    rsp_ready = 1'b1;
    chk({tag, "_ready_idle"}, {31'b0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    req_x     = $urandom;
    req_y     = $urandom;
    req_op    = 3'($urandom_range(0, 7));
    chk({tag, "_busy_exec"}, {31'b0, busy}, 32'd1);
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(exp_n));
    chk({tag, "_z"}, rsp_z, exp_z);
    chk({tag, "_ready_resp"}, {31'b0, req_ready}, 32'd0);
`ifdef LOGIC_SEQ_ERR_EN
    chk({tag, "_err"}, {31'b0, rsp_err}, {31'b0, (op == 3'd7)});
`endif
    tick();
    chk({tag, "_valid_done"}, {31'b0, rsp_valid}, 32'd0);
    chk({tag, "_ready_back"}, {31'b0, req_ready}, 32'd1);
    chk({tag, "_busy_done"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int n;
    int accepts;
    int hs;
    logic [31:0] got [0:3];
    logic acc;

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = 3'd0;
    req_x     = '0;
    req_y     = '0;
    rsp_ready = 1'b0;
    #2;
    chk("rst_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_z", rsp_z, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rel_ready", {31'b0, req_ready}, 32'd1);
    chk("rel_valid", {31'b0, rsp_valid}, 32'd0);

    // 1: AND
    run("and", 3'd0, 32'hDEADBEEF, 32'hCAFEBABE, 32'hCAACBAAE, 1);
    // 2: XOR and XNOR
    run("xor", 3'd5, 32'hAAAAAAAA, 32'h55555555, 32'hFFFFFFFF, 4);
    run("xnor", 3'd6, 32'h12345678, 32'h87654321, 32'h6AAEEAA6, 5);
    run("or", 3'd1, 32'h00F0000F, 32'h0F00F000, 32'h0FF0F00F, 1);
    run("nand", 3'd3, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FFF0FFF, 2);

    // 3: backpressure with operand changes after accept and a pending second request
    req_valid = 1'b1;
    req_op    = 3'd4;
    req_x     = 32'h0;
    req_y     = 32'h0;
    rsp_ready = 1'b0;
    tick();
    req_x  = 32'hFFFFFFFF;
    req_y  = 32'h0F0F0F0F;
    req_op = 3'd0;
    chk("bp_ready_exec", {31'b0, req_ready}, 32'd0);
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    chk("bp_latency", 32'(n), 32'd2);
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_valid", {31'b0, rsp_valid}, 32'd1);
      chk("bp_hold_z", rsp_z, 32'hFFFFFFFF);
      chk("bp_hold_ready", {31'b0, req_ready}, 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_valid_done", {31'b0, rsp_valid}, 32'd0);
    chk("bp_ready_back", {31'b0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    chk("bp2_busy", {31'b0, busy}, 32'd1);
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    chk("bp2_latency", 32'(n), 32'd1);
    chk("bp2_z", rsp_z, 32'h0F0F0F0F);
    tick();

    // 4: reset in the middle of an XOR
    req_valid = 1'b1;
    req_op    = 3'd5;
    req_x     = 32'h0000FFFF;
    req_y     = 32'h00FF00FF;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    chk("mid_busy", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, rsp_valid}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_z", rsp_z, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    hs = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rsp_valid) hs++;
    end
    chk("mid_no_stale", 32'(hs), 32'd0);
    run("not", 3'd2, 32'h80000000, 32'h12345678, 32'h7FFFFFFF, 1);

    // 5: back-to-back with req_valid held high
    req_valid = 1'b1;
    req_op    = 3'd3;
    req_x     = 32'hFFFFFFFF;
    req_y     = 32'h0000FFFF;
    rsp_ready = 1'b1;
    accepts   = 0;
    hs        = 0;
    for (int i = 0; i < 4; i++) got[i] = '0;
    for (int i = 0; i < 14; i++) begin
      acc = req_valid && req_ready;
      if (rsp_valid && rsp_ready) begin
        if (hs < 4) got[hs] = rsp_z;
        hs++;
      end
      tick();
      if (acc) begin
        accepts++;
        if (accepts == 1) begin
          req_op = 3'd1;
          req_x  = 32'h00000001;
          req_y  = 32'h80000000;
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    chk("b2b_accepts", 32'(accepts), 32'd2);
    chk("b2b_handshakes", 32'(hs), 32'd2);
    chk("b2b_first", got[0], 32'hFFFF0000);
    chk("b2b_second", got[1], 32'h80000001);

    // 6: illegal op, then a normal op
    run("illegal", 3'd7, 32'h12345678, 32'hFFFFFFFF, 32'h00000000, 1);
    run("and_after", 3'd0, 32'hFFFF0000, 32'h12345678, 32'h12340000, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
